// File: rtl/uart_mmio_periph.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers, combinational read data, level irq.
// Independent TX and RX FSMs, each with its own baud counter; RX input is 2-flop synchronized.
`timescale 1ns/1ps
module uart_mmio_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          BAUD_DIV  = 5208
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        irq,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int             CW    = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]  HALF  = CW'(BAUD_DIV / 2 - 1);
  localparam logic [31:0]    TXD_A = BASE_ADDR + 32'h18;
  localparam logic [31:0]    RXD_A = BASE_ADDR + 32'h1C;
  localparam logic [31:0]    CON_A = BASE_ADDR + 32'h20;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic hit_txd, hit_rxd, hit_con;
  logic txd_wr, con_wr, rxd_rd, con_rd;

  assign hit_txd = (Address[31:2] == TXD_A[31:2]);
  assign hit_rxd = (Address[31:2] == RXD_A[31:2]);
  assign hit_con = (Address[31:2] == CON_A[31:2]);
  assign txd_wr  = MemWrite && hit_txd;
  assign con_wr  = MemWrite && hit_con;
  assign rxd_rd  = MemRead && hit_rxd;
  assign con_rd  = MemRead && hit_con;

  logic unused_bits;
  assign unused_bits = ^{WriteData[31:8], Address[1:0]};

  logic       tx_irq_en, rx_irq_en;
  logic       tx_done, tx_busy;
  logic       rx_ready, overrun, frame_err;
  logic [7:0] rx_byte;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_irq_en <= 1'b0;
      rx_irq_en <= 1'b0;
    end else if (con_wr) begin
      tx_irq_en <= WriteData[0];
      rx_irq_en <= WriteData[1];
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      if (hit_rxd)
        ReadData = {24'b0, rx_byte};
      else if (hit_con)
        ReadData = {25'b0, frame_err, overrun, tx_busy, rx_ready, tx_done, rx_irq_en, tx_irq_en};
    end
  end

  assign irq = (tx_done & tx_irq_en) | (rx_ready & rx_irq_en);

  // Transmitter
  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bits;
  logic [7:0]    tx_sh;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_sh    <= '0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      // clear first so a completing frame on the same edge keeps tx_done set
      if (con_rd) tx_done <= 1'b0;
      case (tx_state)
        S_IDLE: begin
          if (txd_wr) begin
            tx_sh    <= WriteData[7:0];
            tx_cnt   <= '0;
            uart_tx  <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            uart_tx  <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_bits  <= '0;
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            if (tx_bits == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              uart_tx <= tx_sh[0];
              tx_sh   <= {1'b0, tx_sh[7:1]};
              tx_bits <= tx_bits + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_done  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // Receiver; synchronizer resets to the idle-high line level
  logic          rx_meta, rxs;
  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bits;
  logic [7:0]    rx_sh;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_bits   <= '0;
      rx_sh     <= '0;
      rx_byte   <= '0;
      rx_ready  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
      if (rxd_rd) rx_ready <= 1'b0;
      if (con_rd) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      case (rx_state)
        S_IDLE: begin
          if (!rxs) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == HALF) begin
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_state <= rxs ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rxs, rx_sh[7:1]};
            if (rx_bits == 3'd7) rx_state <= S_STOP;
            else                 rx_bits  <= rx_bits + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt == LAST) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
            if (rxs) begin
              rx_byte  <= rx_sh;
              if (rx_ready) overrun <= 1'b1;
              rx_ready <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_periph.sv
// Directed bench for uart_mmio_periph at BAUD_DIV=8: registers, TX framing, RX, overrun, glitch, frame error.
`timescale 1ns/1ps
module tb_uart_mmio_periph;
  localparam int          BD   = 8;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] TXD  = BASE + 32'h18;
  localparam logic [31:0] RXD  = BASE + 32'h1C;
  localparam logic [31:0] CON  = BASE + 32'h20;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        uart_rx = 1'b1;
  wire  [31:0] ReadData;
  wire         irq;
  wire         uart_tx;

  int errors = 0;
  int checks = 0;

  uart_mmio_periph #(.BASE_ADDR(BASE), .BAUD_DIV(BD)) dut (
    .clk(clk), .reset_b(reset_b), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .irq(irq),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Address = a; WriteData = d; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0; Address = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    Address = a; MemRead = 1'b1;
    #1 d = ReadData;
    @(negedge clk);
    MemRead = 1'b0; Address = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_bit(input logic b);
    uart_rx = b;
    repeat (BD) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop);
    uart_rx = 1'b1;
  endtask

  // Collects 80 line samples from the first low cycle, polling CON for tx_busy alongside.
  task automatic capture_frame(input bit inject, output logic [79:0] line,
                               output int busy_cnt, output bit found);
    found = 1'b0;
    busy_cnt = 0;
    line = '0;
    for (int w = 0; w < 3 && !found; w++) begin
      if (uart_tx === 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    if (found) begin
      for (int k = 0; k < 80; k++) begin
        if (inject && k == 20) begin
          MemRead = 1'b0; Address = TXD; WriteData = 32'h3C; MemWrite = 1'b1;
          #1 line[k] = uart_tx;
        end else begin
          MemWrite = 1'b0; Address = CON; MemRead = 1'b1;
          #1 line[k] = uart_tx;
          if (ReadData[4] === 1'b1) busy_cnt++;
        end
        @(negedge clk);
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0; Address = '0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    idle(2);
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", ReadData); end
    reset_b = 1'b1;
    bus_write(TXD, 32'h00);
    uart_rx = 1'b0;
    idle(20);
    #1;
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_tx: got %b expected 0", uart_tx); end
    #1 reset_b = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b expected 1", uart_tx); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
    uart_rx = 1'b1;
    idle(3);
    reset_b = 1'b1;
    bus_read(CON, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_con: got %h expected 0", rd); end
    bus_read(RXD, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_rxd: got %h expected 0", rd); end
    idle(100);
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %b expected 1", uart_tx); end
  endtask

  task automatic test_con;
    logic [31:0] rd;
    bus_write(CON, 32'hFFFF_FFFF);
    bus_read(CON, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL con_mask: got %h expected 3", rd); end
    bus_read(CON | 32'h3, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL con_low_bits_ignored: got %h expected 3", rd); end
    bus_write(BASE + 32'h24, 32'h0);
    bus_read(BASE + 32'h24, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL nohit_read: got %h expected 0", rd); end
    @(negedge clk);
    Address = CON;
    #1;
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL rdata_no_memread: got %h expected 0", ReadData); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_no_flags: got %b expected 0", irq); end
    Address = '0;
    bus_read(CON, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL nohit_no_effect: got %h expected 3", rd); end
    bus_write(CON, 32'h1);
  endtask

  task automatic test_tx;
    logic [31:0] rd;
    logic [79:0] line;
    logic [9:0]  exp_f;
    int          busy_cnt;
    bit          found, bad;
    exp_f = {1'b1, 8'hA5, 1'b0};
    bus_write(TXD, 32'hA5);
    capture_frame(1'b0, line, busy_cnt, found);
    checks++; if (!found) begin errors++; $display("FAIL tx_start: got no low within 3 cycles expected start bit"); end
    for (int s = 0; s < 10; s++) begin
      bad = 1'b0;
      for (int j = 0; j < 8; j++) if (line[s*8+j] !== exp_f[s]) bad = 1'b1;
      checks++;
      if (bad) begin errors++; $display("FAIL tx_slot%0d: got %b expected %b x8", s, line[s*8 +: 8], exp_f[s]); end
    end
    checks++; if (busy_cnt != 80) begin errors++; $display("FAIL tx_busy_cycles: got %0d expected 80", busy_cnt); end
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_after_stop: got %b expected 1", uart_tx); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tx_irq: got %b expected 1", irq); end
    bus_read(CON, rd);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL tx_done_con: got %h expected 5", rd); end
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tx_irq_cleared: got %b expected 0", irq); end
    bus_read(CON, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL tx_done_cleared: got %h expected 1", rd); end
  endtask

  task automatic test_tx_drop;
    logic [31:0] rd;
    logic [79:0] line;
    logic [9:0]  exp_f;
    int          busy_cnt;
    bit          found, bad;
    exp_f = {1'b1, 8'hA5, 1'b0};
    bus_write(TXD, 32'hA5);
    capture_frame(1'b1, line, busy_cnt, found);
    checks++; if (!found) begin errors++; $display("FAIL drop_start: got no low within 3 cycles expected start bit"); end
    bad = 1'b0;
    for (int k = 0; k < 80; k++) if (line[k] !== exp_f[k/8]) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL drop_frame: got %h expected frame of 0xA5", line); end
    checks++; if (busy_cnt != 79) begin errors++; $display("FAIL drop_busy_cycles: got %0d expected 79", busy_cnt); end
    bus_read(CON, rd);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL drop_done: got %h expected 5", rd); end
    bad = 1'b0;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      #1 if (uart_tx !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL drop_second_frame: got low on line expected idle"); end
    bus_read(CON, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL drop_no_done: got %h expected 1", rd); end
  endtask

  task automatic test_rx;
    logic [31:0] rd;
    bus_write(CON, 32'h2);
    rx_frame(8'h5A, 1'b1);
    #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq: got %b expected 1", irq); end
    bus_read(RXD, rd);
    checks++; if (rd !== 32'h5A) begin errors++; $display("FAIL rx_data: got %h expected 0000005a", rd); end
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_cleared: got %b expected 0", irq); end
    bus_read(CON, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL rx_ready_cleared: got %h expected 2", rd); end
  endtask

  task automatic test_overrun;
    logic [31:0] rd;
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    bus_read(CON, rd);
    checks++; if (rd !== 32'h2A) begin errors++; $display("FAIL overrun_set: got %h expected 2a", rd); end
    bus_read(CON, rd);
    checks++; if (rd !== 32'h0A) begin errors++; $display("FAIL overrun_cleared: got %h expected 0a", rd); end
    #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL overrun_irq: got %b expected 1", irq); end
    bus_read(RXD, rd);
    checks++; if (rd !== 32'h22) begin errors++; $display("FAIL overrun_data: got %h expected 00000022", rd); end
    bus_read(CON, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL overrun_final_con: got %h expected 2", rd); end
  endtask

  task automatic test_glitch_frame_err;
    logic [31:0] rd;
    @(negedge clk);
    uart_rx = 1'b0;
    idle(2);
    uart_rx = 1'b1;
    idle(30);
    bus_read(CON, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL glitch_no_flags: got %h expected 2", rd); end
    rx_frame(8'h77, 1'b0);
    idle(20);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ferr_irq: got %b expected 0", irq); end
    bus_read(CON, rd);
    checks++; if (rd !== 32'h42) begin errors++; $display("FAIL ferr_set: got %h expected 42", rd); end
    bus_read(RXD, rd);
    checks++; if (rd !== 32'h22) begin errors++; $display("FAIL ferr_byte_kept: got %h expected 00000022", rd); end
    bus_read(CON, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL ferr_cleared: got %h expected 2", rd); end
  endtask

  initial begin
    test_reset();
    test_con();
    test_tx();
    test_tx_drop();
    test_rx();
    test_overrun();
    test_glitch_frame_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
